// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: FSM encoding and default mem-side widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles without memAck; expired marks the cycle whose edge ends the access.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // cnt holds the number of already-elapsed waiting edges, so this edge is number TIMEOUT
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins ties.
// Optional bus timeout enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ifReq,
  input  logic [ADDR_W-1:0]   ifAddr,
  output logic [DATA_W-1:0]   ifRdata,
  output logic                ifAck,
  input  logic                dReq,
  input  logic                dWE,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W-1:0]   dWdata,
  input  logic [DATA_W/8-1:0] dMask,
  output logic [DATA_W-1:0]   dRdata,
  output logic                dAck,
  output logic                memReq,
  output logic                memWE,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memMask,
  input  logic [DATA_W-1:0]   memRdata,
  input  logic                memAck,
  output logic                busErr
);

  localparam int MW = DATA_W / 8;

  arb_state_e        state, state_n;
  logic              mem_req_n, mem_we_n, if_ack_n, d_ack_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;
  logic [MW-1:0]     mem_mask_n;
  logic              tmo;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state != IDLE) && !memAck),
    .expired(tmo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busErr <= 1'b0;
    else       busErr <= tmo;
  end
`else
  // TIMEOUT has no effect without the timeout build
  assign tmo    = 1'b0 & (TIMEOUT > 0);
  assign busErr = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    mem_req_n   = memReq;
    mem_we_n    = memWE;
    mem_addr_n  = memAddr;
    mem_wdata_n = memWdata;
    mem_mask_n  = memMask;
    if_rdata_n  = ifRdata;
    d_rdata_n   = dRdata;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    case (state)
      IDLE: begin
        // ack gating keeps a just-completed requester from being re-granted
        if (dReq && !dAck) begin
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = dWE;
          mem_addr_n  = dAddr;
          mem_wdata_n = dWdata;
          mem_mask_n  = dMask;
        end else if (ifReq && !ifAck) begin
          state_n     = BUSY_IF;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = ifAddr;
          mem_wdata_n = '0;
          mem_mask_n  = '1;
        end
      end
      BUSY_IF: begin
        if (memAck || tmo) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          if_ack_n   = 1'b1;
          if_rdata_n = memAck ? memRdata : '0;
        end
      end
      BUSY_D: begin
        if (memAck || tmo) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          d_ack_n   = 1'b1;
          d_rdata_n = (memAck && !memWE) ? memRdata : '0;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWE    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memMask  <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
    end else begin
      state    <= state_n;
      memReq   <= mem_req_n;
      memWE    <= mem_we_n;
      memAddr  <= mem_addr_n;
      memWdata <= mem_wdata_n;
      memMask  <= mem_mask_n;
      ifRdata  <= if_rdata_n;
      dRdata   <= d_rdata_n;
      ifAck    <= if_ack_n;
      dAck     <= d_ack_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int TMO = 8;

  logic          clk = 1'b0, reset = 1'b0;
  logic          ifReq = 1'b0, dReq = 1'b0, dWE = 1'b0, memAck = 1'b0;
  logic [AW-1:0] ifAddr = '0, dAddr = '0, memAddr;
  logic [DW-1:0] dWdata = '0, memRdata = '0, ifRdata, dRdata, memWdata;
  logic [MW-1:0] dMask = '0, memMask;
  logic          ifAck, dAck, memReq, memWE, busErr;

  int checks = 0, errors = 0;
  bit run = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifAck(ifAck),
    .dReq(dReq), .dWE(dWE), .dAddr(dAddr), .dWdata(dWdata), .dMask(dMask),
    .dRdata(dRdata), .dAck(dAck),
    .memReq(memReq), .memWE(memWE), .memAddr(memAddr), .memWdata(memWdata),
    .memMask(memMask), .memRdata(memRdata), .memAck(memAck), .busErr(busErr)
  );

  always #5 clk = ~clk;

  // owner: 0 = port free, 1 = fetch, 2 = data; busy = cycles memReq has been up
  typedef struct {
    int            owner;
    int            busy;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] mask;
    logic          if_ack, d_ack, err;
    logic [DW-1:0] if_rdata, d_rdata;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.owner = 0; z.busy = 0; z.we = 0; z.addr = '0; z.wdata = '0; z.mask = '0;
    z.if_ack = 0; z.d_ack = 0; z.err = 0; z.if_rdata = '0; z.d_rdata = '0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c);
    mdl_t n = c;
    bit done, bad;
    logic [DW-1:0] rd;
    n.if_ack = 0; n.d_ack = 0; n.err = 0;
    if (c.owner == 0) begin
      if (dReq && !c.d_ack) begin
        n.owner = 2; n.busy = 1; n.we = dWE; n.addr = dAddr; n.wdata = dWdata; n.mask = dMask;
      end else if (ifReq && !c.if_ack) begin
        n.owner = 1; n.busy = 1; n.we = 0; n.addr = ifAddr; n.mask = '1;
      end
    end else begin
      done = memAck;
      bad  = 0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      if (!memAck && c.busy == TMO) begin done = 1; bad = 1; end
`endif
      if (done) begin
        rd = (bad || (c.owner == 2 && c.we)) ? '0 : memRdata;
        if (c.owner == 1) begin n.if_ack = 1; n.if_rdata = rd; end
        else              begin n.d_ack  = 1; n.d_rdata  = rd; end
        n.err = bad; n.owner = 0;
      end else begin
        n.busy = c.busy + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m = mdl_zero();
    else       m = mdl_step(m);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("memReq", 64'(memReq), 64'(m.owner != 0));
      chk("ifAck", 64'(ifAck), 64'(m.if_ack));
      chk("dAck", 64'(dAck), 64'(m.d_ack));
      chk("busErr", 64'(busErr), 64'(m.err));
      chk("ack_overlap", 64'(ifAck & dAck), 64'(0));
      if (m.owner != 0) begin
        chk("memWE", 64'(memWE), 64'(m.we));
        chk("memAddr", 64'(memAddr), 64'(m.addr));
        chk("memMask", 64'(memMask), 64'(m.mask));
        if (m.we) chk("memWdata", 64'(memWdata), 64'(m.wdata));
      end
      if (m.if_ack) chk("ifRdata", 64'(ifRdata), 64'(m.if_rdata));
      if (m.d_ack)  chk("dRdata", 64'(dRdata), 64'(m.d_rdata));
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    m = mdl_zero();
    #1 reset = 1'b1;
    run = 1'b1;
    repeat (2) nxt();
    reset = 1'b0;
    nxt();
    chk("rst_memReq", 64'(memReq), 64'(0));
    chk("rst_acks", 64'({ifAck, dAck, busErr}), 64'(0));
    chk("rst_memAddr", 64'(memAddr), 64'(0));

    // single zero-wait fetch, request held through its ack
    ifReq = 1; ifAddr = 32'h100; nxt();
    chk("t1_memReq", 64'(memReq), 64'(1));
    chk("t1_memWE", 64'(memWE), 64'(0));
    chk("t1_memAddr", 64'(memAddr), 64'h100);
    chk("t1_memMask", 64'(memMask), 64'hf);
    memAck = 1; memRdata = 32'h00500093; nxt();
    memAck = 0; memRdata = 32'h11111111;
    chk("t1_ifAck", 64'(ifAck), 64'(1));
    chk("t1_ifRdata", 64'(ifRdata), 64'h00500093);
    chk("t1_memReq_low", 64'(memReq), 64'(0));
    nxt();
    chk("t6_no_regrant", 64'(memReq), 64'(0));
    chk("t6_ack_once", 64'(ifAck), 64'(0));
    ifReq = 0; nxt();

    // store and fetch together: data first, fetch granted in the dAck cycle
    dReq = 1; dWE = 1; dAddr = 32'h2000; dWdata = 32'hDEADBEEF; dMask = 4'b0011;
    ifReq = 1; ifAddr = 32'h300; nxt();
    chk("t2_memWE", 64'(memWE), 64'(1));
    chk("t2_memAddr", 64'(memAddr), 64'h2000);
    chk("t2_memWdata", 64'(memWdata), 64'hDEADBEEF);
    chk("t2_memMask", 64'(memMask), 64'h3);
    memAck = 1; memRdata = 32'h12345678; nxt();
    memAck = 0; dReq = 0;
    chk("t2_dAck", 64'(dAck), 64'(1));
    chk("t2_dRdata", 64'(dRdata), 64'(0));
    chk("t2_ifAck_quiet", 64'(ifAck), 64'(0));
    nxt();
    chk("t2_if_grant", 64'(memReq), 64'(1));
    chk("t2_if_addr", 64'(memAddr), 64'h300);
    chk("t2_if_we", 64'(memWE), 64'(0));
    memAck = 1; memRdata = 32'hCAFE0001; nxt();
    memAck = 0; ifReq = 0;
    chk("t2_ifAck", 64'(ifAck), 64'(1));
    chk("t2_ifRdata", 64'(ifRdata), 64'hCAFE0001);
    chk("t2_dAck_quiet", 64'(dAck), 64'(0));
    nxt();

    // load with 5 wait cycles; request fields wiggle while busy
    dReq = 1; dWE = 0; dAddr = 32'h44; dMask = 4'hf; nxt();
    for (int i = 0; i < 6; i++) begin
      chk("t3_hold_req", 64'(memReq), 64'(1));
      chk("t3_hold_addr", 64'(memAddr), 64'h44);
      chk("t3_hold_we", 64'(memWE), 64'(0));
      dAddr = $urandom; dWE = 1'($urandom);
      if (i < 5) nxt();
    end
    memAck = 1; memRdata = 32'hA5A50F0F; nxt();
    memAck = 0; dReq = 0;
    chk("t3_dAck", 64'(dAck), 64'(1));
    chk("t3_dRdata", 64'(dRdata), 64'hA5A50F0F);
    nxt();
    chk("t3_dAck_once", 64'(dAck), 64'(0));

    // reset mid-access, then a late memAck
    dReq = 1; dWE = 0; dAddr = 32'h88; nxt();
    chk("t4_busy", 64'(memReq), 64'(1));
    reset = 1; dReq = 0; #1;
    chk("t4_async", 64'({memReq, memWE, ifAck, dAck, busErr}), 64'(0));
    chk("t4_addr0", 64'(memAddr), 64'(0));
    nxt();
    reset = 0; nxt();
    memAck = 1; memRdata = 32'h77777777; nxt();
    memAck = 0;
    chk("t4_late_ack", 64'({memReq, ifAck, dAck, busErr}), 64'(0));
    chk("t4_rdata0", 64'(dRdata), 64'(0));
    nxt();

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // memory never answers: port released after TMO busy cycles with busErr
    ifReq = 1; ifAddr = 32'h80; nxt();
    for (int i = 0; i < TMO; i++) begin
      chk("t5_wait", 64'(memReq), 64'(1));
      if (i < TMO - 1) nxt();
    end
    nxt();
    ifReq = 0;
    chk("t5_drop", 64'(memReq), 64'(0));
    chk("t5_err", 64'({ifAck, busErr}), 64'b11);
    chk("t5_rdata", 64'(ifRdata), 64'(0));
    nxt();
    chk("t5_err_once", 64'(busErr), 64'(0));
    // memAck on the timeout edge wins
    ifReq = 1; ifAddr = 32'h84; nxt();
    repeat (TMO - 1) nxt();
    memAck = 1; memRdata = 32'h5A5A5A5A; nxt();
    memAck = 0; ifReq = 0;
    chk("t5_race_ok", 64'({ifAck, busErr}), 64'b10);
    chk("t5_race_data", 64'(ifRdata), 64'h5A5A5A5A);
    nxt();
`endif

    // random traffic: spurious acks, held requests, field churn, rare resets
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if (ifReq) begin
        if (m.if_ack && $urandom_range(0, 3) != 0) ifReq = 0;
      end else ifReq = ($urandom_range(0, 2) == 0);
      if (dReq) begin
        if (m.d_ack && $urandom_range(0, 3) != 0) dReq = 0;
      end else dReq = ($urandom_range(0, 2) == 0);
      ifAddr = $urandom; dAddr = $urandom; dWdata = $urandom;
      dWE = 1'($urandom); dMask = 4'($urandom);
      memRdata = $urandom;
      memAck = (m.owner != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      nxt();
    end
    reset = 0; ifReq = 0; dReq = 0; memAck = 0;
    repeat (2) nxt();
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
